// File: rtl/pic_read_write.sv
// Read/write control and command-register block of an 8259A-style interrupt
// controller. CPU bus writes are edge-detected on the active-low strobes and
// steered into ICW1..ICW4 / OCW1..OCW3 by an initialization sequencer, so the
// same A0 address lands in different registers depending on sequence position.
module pic_read_write (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Data_in,
  input  logic       WR,
  input  logic       CS,
  input  logic       RD,
  input  logic       A0,
  output logic [7:0] ICW1,
  output logic [7:0] ICW2,
  output logic [7:0] ICW3,
  output logic [7:0] ICW4,
  output logic [7:0] OCW1,
  output logic [7:0] OCW2,
  output logic [7:0] OCW3
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic       wr_act;
  logic       wr_act_q;
  logic       armed_q;
  logic       commit;
  logic       is_icw1;

  logic [7:0] icw1_d;
  logic [7:0] icw2_d;
  logic [7:0] icw3_d;
  logic [7:0] icw4_d;
  logic [7:0] ocw1_d;
  logic [7:0] ocw2_d;
  logic [7:0] ocw3_d;

  // A bus write is active only while selected, strobed, and not also reading.
  assign wr_act  = !CS && !WR && RD;

  // One commit per strobe: fire on the first edge the write is seen active.
  // armed_q blocks a strobe that was already low when reset released, so a
  // fresh falling pulse is needed before anything can commit.
  assign commit  = wr_act && !wr_act_q && armed_q;

  // ICW1 is recognised by address and data pattern in every state.
  assign is_icw1 = !A0 && Data_in[4];

  // Strobe history for the edge detector and the post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop, independent of order.
      wr_act_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      if (!wr_act) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Next-state and register-update decode for a committed write.
  always_comb begin
    // NOTE: every signal is given a hold value first, so paths that do not
    // assign it keep the register contents instead of inferring a latch.
    state_d = state_q;
    icw1_d  = ICW1;
    icw2_d  = ICW2;
    icw3_d  = ICW3;
    icw4_d  = ICW4;
    ocw1_d  = OCW1;
    ocw2_d  = OCW2;
    ocw3_d  = OCW3;

    if (commit) begin
      if (is_icw1) begin
        // ICW1 restarts initialization from any state.
        icw1_d  = Data_in;
        ocw1_d  = 8'h00;
        if (!Data_in[0]) begin
          icw4_d = 8'h00;
        end
        state_d = WAIT_ICW2;
      end else begin
        unique case (state_q)
          WAIT_ICW2: begin
            if (A0) begin
              icw2_d = Data_in;
              if (!ICW1[1]) begin
                state_d = WAIT_ICW3;
              end else if (ICW1[0]) begin
                state_d = WAIT_ICW4;
              end else begin
                state_d = READY;
              end
            end
          end
          WAIT_ICW3: begin
            if (A0) begin
              icw3_d  = Data_in;
              state_d = ICW1[0] ? WAIT_ICW4 : READY;
            end
          end
          WAIT_ICW4: begin
            if (A0) begin
              icw4_d  = Data_in;
              state_d = READY;
            end
          end
          READY: begin
            if (A0) begin
              ocw1_d = Data_in;
            end else if (!Data_in[3]) begin
              ocw2_d = Data_in;
            end else begin
              ocw3_d = Data_in;
            end
          end
          default: begin
            // UNINIT: only ICW1 is honoured, handled above.
          end
        endcase
      end
    end
  end

  // State and command-word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNINIT;
      ICW1    <= 8'h00;
      ICW2    <= 8'h00;
      ICW3    <= 8'h00;
      ICW4    <= 8'h00;
      OCW1    <= 8'h00;
      OCW2    <= 8'h00;
      OCW3    <= 8'h00;
    end else begin
      state_q <= state_d;
      ICW1    <= icw1_d;
      ICW2    <= icw2_d;
      ICW3    <= icw3_d;
      ICW4    <= icw4_d;
      OCW1    <= ocw1_d;
      OCW2    <= ocw2_d;
      OCW3    <= ocw3_d;
    end
  end

endmodule

// File: tb/tb_pic_read_write.sv
// Self-checking bench for pic_read_write. A queue-based reference model tracks
// which initialization words are still owed after each ICW1 and routes writes
// accordingly; every scenario compares all seven outputs against it.
module tb_pic_read_write;

  logic       clk;
  logic       rst_n;
  logic [7:0] Data_in;
  logic       WR;
  logic       CS;
  logic       RD;
  logic       A0;
  logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: m[0..6] = ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3.
  logic [7:0] m [7];
  int         pending[$];
  bit         inited;

  pic_read_write dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Data_in (Data_in),
    .WR      (WR),
    .CS      (CS),
    .RD      (RD),
    .A0      (A0),
    .ICW1    (ICW1),
    .ICW2    (ICW2),
    .ICW3    (ICW3),
    .ICW4    (ICW4),
    .OCW1    (OCW1),
    .OCW2    (OCW2),
    .OCW3    (OCW3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] dut_regs();
    return {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3};
  endfunction

  function automatic logic [55:0] model_regs();
    return {m[0], m[1], m[2], m[3], m[4], m[5], m[6]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m[i] = 8'h00;
    pending.delete();
    inited = 1'b0;
  endtask

  // One accepted write as the 8259A rules describe it.
  task automatic model_write(input logic a0, input logic [7:0] d);
    if (!a0 && d[4]) begin
      m[0] = d;
      m[4] = 8'h00;
      if (!d[0]) m[3] = 8'h00;
      pending.delete();
      pending.push_back(1);
      if (!d[1]) pending.push_back(2);
      if (d[0])  pending.push_back(3);
      inited = 1'b1;
    end else if (pending.size() > 0) begin
      if (a0) m[pending.pop_front()] = d;
    end else if (inited) begin
      if (a0)         m[4] = d;
      else if (!d[3]) m[5] = d;
      else            m[6] = d;
    end
  endtask

  // One-clock strobe pulse; the model follows only if the write is valid.
  task automatic bus_write(input logic a0, input logic [7:0] d,
                           input logic cs_n = 1'b0, input logic rd_n = 1'b1);
    @(negedge clk);
    A0 = a0; Data_in = d; CS = cs_n; RD = rd_n; WR = 1'b0;
    @(negedge clk);
    WR = 1'b1; CS = 1'b1; RD = 1'b1;
    if (!cs_n && rd_n) model_write(a0, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    WR = 1'b1; CS = 1'b1; RD = 1'b1; A0 = 1'b0; Data_in = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL reset_in: got %h want %h", dut_regs(), model_regs());
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (dut_regs() !== 56'h0) begin
      miscompares++;
      $display("FAIL reset_out: got %h want %h", dut_regs(), 56'h0);
    end
  endtask

  task automatic test_cascade_init();
    logic [7:0] a [4] = '{8'hD5, 8'hE8, 8'h0B, 8'h00};
    for (int i = 0; i < 4; i++) begin
      bus_write(i != 0, a[i]);
      vectors++;
      if (dut_regs() !== model_regs()) begin
        miscompares++;
        $display("FAIL cascade_step%0d: got %h want %h", i, dut_regs(), model_regs());
      end
    end
  endtask

  task automatic test_ocw();
    logic [7:0] d [3]  = '{8'h1F, 8'hE0, 8'h68};
    logic       a [3]  = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus_write(a[i], d[i]);
      vectors++;
      if (dut_regs() !== model_regs()) begin
        miscompares++;
        $display("FAIL ocw_write%0d: got %h want %h", i, dut_regs(), model_regs());
      end
    end
  endtask

  task automatic test_single_mode();
    // SNGL=1, IC4=1: ICW2 then ICW4, ICW3 skipped.
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, 8'h03);
    vectors++;
    if (dut_regs() !== model_regs() || ICW4 !== 8'h03 || ICW2 !== 8'h20) begin
      miscompares++;
      $display("FAIL single_ic4: got %h want %h", dut_regs(), model_regs());
    end
    // SNGL=1, IC4=0: ready after ICW2; next A0=1 goes to OCW1.
    bus_write(1'b0, 8'h12);
    bus_write(1'b1, 8'h44);
    bus_write(1'b1, 8'h77);
    vectors++;
    if (dut_regs() !== model_regs() || OCW1 !== 8'h77 || ICW4 !== 8'h00) begin
      miscompares++;
      $display("FAIL single_noic4: got %h want %h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_gating();
    bus_write(1'b1, 8'hAA, 1'b1, 1'b1);
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL gate_cs: got %h want %h", dut_regs(), model_regs());
    end
    bus_write(1'b1, 8'hBB, 1'b0, 1'b0);
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL gate_rd: got %h want %h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_back_to_back();
    // Strobe held five clocks with data changing after the first edge:
    // only the first edge may commit, with the first data.
    @(negedge clk);
    A0 = 1'b1; Data_in = 8'h5A; CS = 1'b0; RD = 1'b1; WR = 1'b0;
    @(negedge clk);
    Data_in = 8'hA5;
    repeat (4) @(negedge clk);
    WR = 1'b1; CS = 1'b1;
    model_write(1'b1, 8'h5A);
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL held_strobe: got %h want %h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_robustness();
    do_reset();
    bus_write(1'b1, 8'hFF);
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL preinit_ocw1: got %h want %h", dut_regs(), model_regs());
    end
    bus_write(1'b0, 8'hD5);
    bus_write(1'b1, 8'h40);
    bus_write(1'b0, 8'h08);  // in WAIT_ICW3: must be ignored
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL midinit_a0low: got %h want %h", dut_regs(), model_regs());
    end
    bus_write(1'b1, 8'h0C);  // lands in ICW3 only if still waiting there
    vectors++;
    if (dut_regs() !== model_regs() || ICW3 !== 8'h0C) begin
      miscompares++;
      $display("FAIL midinit_icw3: got %h want %h", dut_regs(), model_regs());
    end
    // Finish init, program OCW1, then restart mid-use.
    bus_write(1'b1, 8'h01);
    bus_write(1'b1, 8'h3C);
    bus_write(1'b0, 8'h11);
    vectors++;
    if (dut_regs() !== model_regs() || OCW1 !== 8'h00) begin
      miscompares++;
      $display("FAIL restart_icw1: got %h want %h", dut_regs(), model_regs());
    end
    bus_write(1'b1, 8'h90);
    vectors++;
    if (dut_regs() !== model_regs() || ICW2 !== 8'h90) begin
      miscompares++;
      $display("FAIL restart_icw2: got %h want %h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_regs() !== 56'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", dut_regs(), 56'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(1'b1, 8'h5C);
    vectors++;
    if (dut_regs() !== model_regs()) begin
      miscompares++;
      $display("FAIL uninit_a0high: got %h want %h", dut_regs(), model_regs());
    end
    // Strobe already low across reset release must not commit.
    @(negedge clk);
    A0 = 1'b0; Data_in = 8'h13; CS = 1'b0; RD = 1'b1; WR = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (dut_regs() !== 56'h0) begin
      miscompares++;
      $display("FAIL held_through_reset: got %h want %h", dut_regs(), 56'h0);
    end
    WR = 1'b1; CS = 1'b1;
    bus_write(1'b0, 8'h13);
    vectors++;
    if (dut_regs() !== model_regs() || ICW1 !== 8'h13) begin
      miscompares++;
      $display("FAIL fresh_pulse: got %h want %h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       a0;
    logic       cs_n;
    logic       rd_n;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      d    = 8'($urandom);
      a0   = 1'($urandom);
      cs_n = ($urandom_range(0, 9) == 0);
      rd_n = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        a0   = 1'b0;
        d[4] = 1'b1;
      end
      bus_write(a0, d, cs_n, rd_n);
      vectors++;
      if (dut_regs() !== model_regs()) begin
        miscompares++;
        $display("FAIL random%0d a0=%b d=%h: got %h want %h", i, a0, d,
                 dut_regs(), model_regs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_cascade_init();
    test_ocw();
    test_single_mode();
    test_gating();
    test_back_to_back();
    test_robustness();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
